// File: rtl/test_wr_ctrl_64bit_gen_pkg.sv
// Definitions shared by the DDR3 example-design traffic writer and its read checker:
// AXI encodings, writer FSM states and the self-checking data pattern.
package test_wr_ctrl_64bit_gen_pkg;

  localparam logic [2:0]  SIZE_8B    = 3'b011;
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  localparam logic [15:0] STRIPE_HI   = 16'hFFFF;
  localparam logic [15:0] STRIPE_LO   = 16'h0000;
  localparam logic [63:0] STRIPE_BEAT = {STRIPE_LO, STRIPE_HI, STRIPE_LO, STRIPE_HI};

  typedef enum logic [1:0] {
    StIdle,
    StAw,
    StW,
    StB
  } wr_state_e;

  // Upper byte is the random byte, lower byte lets the checker recover it via the address.
  function automatic logic [15:0] pattern16(input logic [7:0] r, input logic [7:0] a);
    return {r, r ^ a};
  endfunction

  // Fibonacci LFSR, taps 8,6,5,4; a nonzero state never maps to zero.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/test_lfsr8.sv
// 8-bit per-beat random byte generator; advances only when step is high.
module test_lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);
  import test_wr_ctrl_64bit_gen_pkg::*;

  logic [7:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= seed;
    end else if (step) begin
      q_q <= lfsr8_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/test_wr_ctrl_64bit_gen.sv
// AXI write traffic generator: one INCR burst per write_en request, carrying
// self-checking address/random data or a fixed stripe, with B-response error counting.
module test_wr_ctrl_64bit_gen #(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DQ_WIDTH    = 16,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CTRL_ADDR_WIDTH-1:0] random_rw_addr,
  input  logic [3:0]                 random_axi_id,
  input  logic [3:0]                 random_axi_len,
  input  logic                       write_en,
  input  logic                       data_pattern_01,
  output logic                       write_done_p,
  output logic                       wr_busy,
  output logic [31:0]                axi_awaddr,
  output logic [7:0]                 axi_awid,
  output logic [7:0]                 axi_awlen,
  output logic [2:0]                 axi_awsize,
  output logic [1:0]                 axi_awburst,
  output logic                       axi_awlock,
  output logic                       axi_awpoison,
  output logic                       axi_awurgent,
  output logic [3:0]                 axi_awqos,
  output logic                       axi_awvalid,
  input  logic                       axi_awready,
  output logic [63:0]                axi_wdata,
  output logic [7:0]                 axi_wstrb,
  output logic                       axi_wlast,
  output logic                       axi_wvalid,
  input  logic                       axi_wready,
  input  logic [7:0]                 axi_bid,
  input  logic [1:0]                 axi_bresp,
  input  logic                       axi_bvalid,
  output logic                       axi_bready,
  output logic [7:0]                 bresp_err_cnt
);
  import test_wr_ctrl_64bit_gen_pkg::*;

  localparam int unsigned DQ_NUM = MEM_DQ_WIDTH / 16;
  localparam int unsigned WA_W   = CTRL_ADDR_WIDTH + 1;

  wr_state_e         state_q, state_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [7:0]        awid_q, awid_d;
  logic [7:0]        awlen_q, awlen_d;
  logic              awvalid_q, awvalid_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              wlast_q, wlast_d;
  logic              wvalid_q, wvalid_d;
  logic              done_q, done_d;
  logic [7:0]        err_q, err_d;
  logic [WA_W-1:0]   word_addr_q, word_addr_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;

  logic [7:0]        lfsr_q;
  logic              lfsr_step;
  logic [WA_W-1:0]   word_addr_inc;
  logic [7:0]        beat_cnt_inc;
  logic              resp_bad;

  function automatic logic [63:0] build_beat(input logic [7:0] r, input logic [7:0] a,
                                             input logic stripe);
    logic [63:0]             beat;
    logic [MEM_DQ_WIDTH-1:0] lane;
    beat = STRIPE_BEAT;
    if (!stripe) begin
      for (int i = 0; i < 4; i++) begin
        lane = {DQ_NUM{pattern16(r, a + 8'(i))}};
        beat[16*i +: 16] = lane[15:0];
      end
    end
    return beat;
  endfunction

  test_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign word_addr_inc = word_addr_q + WA_W'(4);
  assign beat_cnt_inc  = beat_cnt_q + 8'd1;
  assign resp_bad      = (axi_bresp != RESP_OKAY) || (axi_bid != awid_q);

  always_comb begin
    state_d     = state_q;
    awaddr_d    = awaddr_q;
    awid_d      = awid_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wlast_d     = wlast_q;
    wvalid_d    = wvalid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    word_addr_d = word_addr_q;
    beat_cnt_d  = beat_cnt_q;
    lfsr_step   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (write_en) begin
          awaddr_d    = 32'({random_rw_addr, 1'b0});
          awid_d      = {4'b0, random_axi_id};
          awlen_d     = {4'b0, random_axi_len};
          awvalid_d   = 1'b1;
          word_addr_d = {1'b0, random_rw_addr};
          beat_cnt_d  = 8'd0;
          state_d     = StAw;
        end
      end
      StAw: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          wdata_d   = build_beat(lfsr_q, word_addr_q[7:0], data_pattern_01);
          wlast_d   = (awlen_q == 8'd0);
          wvalid_d  = 1'b1;
          state_d   = StW;
        end
      end
      StW: begin
        if (axi_wready) begin
          lfsr_step   = 1'b1;
          beat_cnt_d  = beat_cnt_inc;
          word_addr_d = word_addr_inc;
          if (beat_cnt_q == awlen_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            state_d  = StB;
          end else begin
            // Next beat uses the post-step LFSR value so back-to-back beats need no bubble.
            wdata_d = build_beat(lfsr8_next(lfsr_q), word_addr_inc[7:0], data_pattern_01);
            wlast_d = (beat_cnt_inc == awlen_q);
          end
        end
      end
      StB: begin
        if (axi_bvalid) begin
          done_d  = 1'b1;
          state_d = StIdle;
          if (resp_bad && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      awaddr_q    <= '0;
      awid_q      <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      word_addr_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      awaddr_q    <= awaddr_d;
      awid_q      <= awid_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wlast_q     <= wlast_d;
      wvalid_q    <= wvalid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      word_addr_q <= word_addr_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign write_done_p  = done_q;
  assign wr_busy       = (state_q != StIdle);
  assign axi_awaddr    = awaddr_q;
  assign axi_awid      = awid_q;
  assign axi_awlen     = awlen_q;
  assign axi_awsize    = SIZE_8B;
  assign axi_awburst   = BURST_INCR;
  assign axi_awlock    = 1'b0;
  assign axi_awpoison  = 1'b0;
  assign axi_awurgent  = 1'b0;
  assign axi_awqos     = 4'h0;
  assign axi_awvalid   = awvalid_q;
  assign axi_wdata     = wdata_q;
  assign axi_wstrb     = 8'hFF;
  assign axi_wlast     = wlast_q;
  assign axi_wvalid    = wvalid_q;
  assign axi_bready    = 1'b1;
  assign bresp_err_cnt = err_q;

endmodule

// File: tb/tb_test_wr_ctrl_64bit_gen.sv
// Bench for test_wr_ctrl_64bit_gen: directed vector table, hand-written reset sequence and
// randomized bursts checked every cycle against a transaction-level model.
module tb_test_wr_ctrl_64bit_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] random_rw_addr;
  logic [3:0]  random_axi_id, random_axi_len;
  logic        write_en, data_pattern_01;
  logic        write_done_p, wr_busy;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awid, axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awlock, axi_awpoison, axi_awurgent;
  logic [3:0]  axi_awqos;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [7:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [7:0]  bresp_err_cnt;

  always #5 clk = ~clk;

  test_wr_ctrl_64bit_gen dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .random_rw_addr  (random_rw_addr),
    .random_axi_id   (random_axi_id),
    .random_axi_len  (random_axi_len),
    .write_en        (write_en),
    .data_pattern_01 (data_pattern_01),
    .write_done_p    (write_done_p),
    .wr_busy         (wr_busy),
    .axi_awaddr      (axi_awaddr),
    .axi_awid        (axi_awid),
    .axi_awlen       (axi_awlen),
    .axi_awsize      (axi_awsize),
    .axi_awburst     (axi_awburst),
    .axi_awlock      (axi_awlock),
    .axi_awpoison    (axi_awpoison),
    .axi_awurgent    (axi_awurgent),
    .axi_awqos       (axi_awqos),
    .axi_awvalid     (axi_awvalid),
    .axi_awready     (axi_awready),
    .axi_wdata       (axi_wdata),
    .axi_wstrb       (axi_wstrb),
    .axi_wlast       (axi_wlast),
    .axi_wvalid      (axi_wvalid),
    .axi_wready      (axi_wready),
    .axi_bid         (axi_bid),
    .axi_bresp       (axi_bresp),
    .axi_bvalid      (axi_bvalid),
    .axi_bready      (axi_bready),
    .bresp_err_cnt   (bresp_err_cnt)
  );

  localparam int PIdle = 0, PAw = 1, PW = 2, PB = 3;

  int checks = 0;
  int failures = 0;

  // Transaction model state
  int          phase = PIdle;
  int          beat = 0;
  logic [27:0] req_addr = '0;
  logic [3:0]  req_id = '0, req_len = '0;
  logic [7:0]  m_lfsr = 8'hA5;
  logic [7:0]  m_err = '0;
  logic        done_exp = 1'b0;
  logic        model_valid = 1'b0;
  logic        post_rst = 1'b0;

  // Stimulus modes and captures
  int          aw_mode = 0, w_mode = 0, b_mode = 0, pat_ctr = 0;
  logic        noise = 1'b0, bad_id = 1'b0;
  logic [1:0]  resp_val = 2'b00;
  int          aw_hs = 0, cap_beats = 0, done_cnt = 0;
  logic [31:0] cap_awaddr;
  logic [63:0] cap_b0;
  logic [15:0] cap_b1l0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [63:0] exp_beat(input logic [7:0] r, input logic [27:0] base,
                                           input int k, input logic pat);
    logic [63:0] d;
    logic [7:0]  a;
    if (pat) return 64'h0000_FFFF_0000_FFFF;
    for (int i = 0; i < 4; i++) begin
      a = 8'(int'(base[7:0]) + 4 * k + i);
      d[16*i +: 16] = {r, r ^ a};
    end
    return d;
  endfunction

  // One clock: drive ready/response inputs, sample just before the edge, advance the model.
  task automatic cycle();
    axi_awready = (aw_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (w_mode)
      0:       axi_wready = 1'b1;
      1:       axi_wready = 1'($urandom_range(0, 1));
      default: axi_wready = (pat_ctr % 3 == 0);
    endcase
    pat_ctr++;
    axi_bvalid = (b_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    axi_bresp  = resp_val;
    axi_bid    = {4'b0, req_id} ^ (bad_id ? 8'h80 : 8'h00);
    if (noise && phase != PIdle) write_en = (phase == PW) ? 1'($urandom_range(0, 1)) : 1'b0;
    #4;
    if (model_valid) begin
      check("done_pulse", write_done_p, done_exp);
      check("err_cnt", bresp_err_cnt, m_err);
      check("busy", wr_busy, phase != PIdle);
      check("awvalid", axi_awvalid, phase == PAw);
      check("wvalid", axi_wvalid, phase == PW);
      check("consts", {axi_awsize, axi_awburst, axi_awlock, axi_awpoison, axi_awurgent,
                       axi_awqos, axi_wstrb, axi_bready},
            {3'b011, 2'b01, 3'b000, 4'h0, 8'hFF, 1'b1});
      if (post_rst) begin
        check("rst_aw_fields", {axi_awaddr, axi_awid, axi_awlen}, 64'h0);
        check("rst_wdata", axi_wdata, 64'h0);
        check("rst_wlast", axi_wlast, 1'b0);
      end
      if (phase == PAw)
        check("aw_fields", {axi_awaddr, axi_awid, axi_awlen},
              {4'b0, req_addr, 1'b0, 4'b0, req_id, 4'b0, req_len});
      if (phase == PW) begin
        check("wdata", axi_wdata, exp_beat(m_lfsr, req_addr, beat, data_pattern_01));
        check("wlast", axi_wlast, beat == int'(req_len));
      end
      if (axi_awvalid && axi_awready) begin
        aw_hs++;
        cap_awaddr = axi_awaddr;
      end
      if (axi_wvalid && axi_wready) begin
        if (cap_beats == 0) cap_b0 = axi_wdata;
        if (cap_beats == 1) cap_b1l0 = axi_wdata[15:0];
        cap_beats++;
      end
      if (write_done_p) done_cnt++;
    end
    if (!rst_n) begin
      phase = PIdle; beat = 0; m_lfsr = 8'hA5; m_err = '0; done_exp = 1'b0;
      model_valid = 1'b1; post_rst = 1'b1;
    end else begin
      post_rst = 1'b0;
      done_exp = 1'b0;
      case (phase)
        PIdle: if (write_en) begin
          req_addr = random_rw_addr; req_id = random_axi_id; req_len = random_axi_len;
          phase = PAw;
        end
        PAw: if (axi_awready) begin
          phase = PW; beat = 0;
        end
        PW: if (axi_wready) begin
          m_lfsr = lfsr_next(m_lfsr);
          if (beat == int'(req_len)) phase = PB;
          else beat++;
        end
        default: if (axi_bvalid) begin
          done_exp = 1'b1;
          if (axi_bresp != 2'b00 || axi_bid != {4'b0, req_id})
            m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
          phase = PIdle;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic burst(input logic [27:0] addr, input logic [3:0] id, input logic [3:0] len,
                       input logic pat);
    int n;
    random_rw_addr = addr; random_axi_id = id; random_axi_len = len; data_pattern_01 = pat;
    pat_ctr = 0; cap_beats = 0; cap_b0 = '0; cap_b1l0 = '0; done_cnt = 0;
    write_en = 1'b1;
    cycle();
    write_en = 1'b0;
    n = 0;
    while (phase != PIdle && n < 400) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL burst_timeout: got %0d cycles expected < 400", n);
    end
    cycle();
  endtask

  typedef struct {
    logic        do_rst;
    logic [27:0] addr;
    logic [3:0]  id;
    logic [3:0]  len;
    logic        pat;
    int          wmode;
    logic [1:0]  bresp;
    logic        bad_id;
    logic        noise;
    logic [31:0] exp_awaddr;
    logic [63:0] exp_b0;
    logic        has_b1;
    logic [15:0] exp_b1;
    int          exp_beats;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int aw0;
    int n;
    logic [3:0] rlen;

    vecs[0] = '{1'b1, 28'h10, 4'h3, 4'h0, 1'b0, 0, 2'b00, 1'b0, 1'b0,
                32'h20, 64'hA5B6_A5B7_A5B4_A5B5, 1'b0, 16'h0000, 1, 8'h00};
    vecs[1] = '{1'b1, 28'h10, 4'h5, 4'h3, 1'b0, 2, 2'b00, 1'b0, 1'b1,
                32'h20, 64'hA5B6_A5B7_A5B4_A5B5, 1'b1, 16'h4A5E, 4, 8'h00};
    vecs[2] = '{1'b1, 28'hFE, 4'h1, 4'h1, 1'b0, 0, 2'b00, 1'b0, 1'b0,
                32'h1FC, 64'hA5A4_A5A5_A55A_A55B, 1'b1, 16'h4A48, 2, 8'h00};
    vecs[3] = '{1'b1, 28'h123, 4'h7, 4'h2, 1'b1, 0, 2'b00, 1'b0, 1'b0,
                32'h246, 64'h0000_FFFF_0000_FFFF, 1'b1, 16'hFFFF, 3, 8'h00};
    vecs[4] = '{1'b1, 28'h40, 4'h2, 4'h0, 1'b0, 0, 2'b10, 1'b0, 1'b0,
                32'h80, 64'hA5E6_A5E7_A5E4_A5E5, 1'b0, 16'h0000, 1, 8'h01};
    vecs[5] = '{1'b0, 28'h44, 4'h9, 4'h1, 1'b0, 0, 2'b00, 1'b1, 1'b0,
                32'h88, 64'h4A0D_4A0C_4A0F_4A0E, 1'b1, 16'h95DD, 2, 8'h02};

    rst_n = 1'b0; write_en = 1'b0; data_pattern_01 = 1'b0;
    random_rw_addr = '0; random_axi_id = '0; random_axi_len = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0; axi_bid = '0;
    @(negedge clk);

    // Directed vectors
    foreach (vecs[i]) begin
      if (vecs[i].do_rst) do_reset();
      aw_mode = 0; w_mode = vecs[i].wmode; b_mode = 0; noise = vecs[i].noise;
      resp_val = vecs[i].bresp; bad_id = vecs[i].bad_id;
      aw0 = aw_hs;
      burst(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].pat);
      check("t_awaddr", cap_awaddr, vecs[i].exp_awaddr);
      check("t_beat0", cap_b0, vecs[i].exp_b0);
      if (vecs[i].has_b1) check("t_beat1_lane0", cap_b1l0, vecs[i].exp_b1);
      check("t_beats", cap_beats, vecs[i].exp_beats);
      check("t_done_count", done_cnt, 1);
      check("t_err_cnt", bresp_err_cnt, vecs[i].exp_err);
      check("t_aw_count", aw_hs - aw0, 1);
    end
    noise = 1'b0; resp_val = 2'b00; bad_id = 1'b0;

    // Reset asserted while beat 1 of a four-beat burst is on the bus
    do_reset();
    aw_mode = 0; w_mode = 0; b_mode = 0;
    random_rw_addr = 28'h200; random_axi_id = 4'h4; random_axi_len = 4'h3;
    data_pattern_01 = 1'b0;
    done_cnt = 0;
    write_en = 1'b1;
    cycle();
    write_en = 1'b0;
    n = 0;
    while (!(phase == PW && beat == 1) && n < 20) begin
      cycle();
      n++;
    end
    check("rst_reach_beat1", n < 20, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("rst_no_done", done_cnt, 0);
    burst(28'h10, 4'h3, 4'h0, 1'b0);
    check("rst_lfsr_seed_beat", cap_b0, 64'hA5B6_A5B7_A5B4_A5B5);

    // Randomized bursts with random handshakes and occasional bad responses
    for (int k = 0; k < 40; k++) begin
      aw_mode = 1; w_mode = 1; b_mode = 1;
      noise = 1'($urandom_range(0, 1));
      resp_val = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bad_id = ($urandom_range(0, 7) == 0);
      rlen = 4'($urandom);
      aw0 = aw_hs;
      burst(28'($urandom), 4'($urandom), rlen, 1'($urandom));
      check("rnd_aw_count", aw_hs - aw0, 1);
      check("rnd_done_count", done_cnt, 1);
      check("rnd_beats", cap_beats, int'(rlen) + 1);
    end
    noise = 1'b0; bad_id = 1'b0;

    // Error counter saturation
    aw_mode = 0; w_mode = 0; b_mode = 0; resp_val = 2'b11;
    for (int k = 0; k < 300; k++) burst(28'(k * 8), 4'(k), 4'h0, 1'b0);
    check("err_saturated", bresp_err_cnt, 8'hFF);
    resp_val = 2'b00;
    burst(28'h30, 4'h6, 4'h1, 1'b0);
    check("err_held_at_max", bresp_err_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
